// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_pkg
//  Purpose  : Shared SHA-256 constants, round functions and the controller
//             state type, used by the compression core and the scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        FINAL = 2'd3
    } state_t;

    localparam logic [31:0] c_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] c_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, f, g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, b, c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] a);
        return rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] e);
        return rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_compress_if.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_compress_if
//  Purpose  : Block-start / scheduled-word / digest bundle between the
//             message scheduler side (master) and the compression core (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface sha256_compress_if;
    logic         start_i;
    logic         init_i;
    logic         w_valid_i;
    logic [31:0]  w_i;
    logic         w_ready_o;
    logic         busy_o;
    logic [5:0]   round_o;
    logic         done_o;
    logic [255:0] digest_o;

    modport master (
        output start_i, init_i, w_valid_i, w_i,
        input  w_ready_o, busy_o, round_o, done_o, digest_o
    );

    modport slave (
        input  start_i, init_i, w_valid_i, w_i,
        output w_ready_o, busy_o, round_o, done_o, digest_o
    );
endinterface
`default_nettype wire

// File: rtl/sha256_round.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_round
//  Purpose  : One combinational SHA-256 round. Working variables are packed
//             a..h from MSB to LSB (a in [255:224], h in [31:0]).
//  Revision : 1.0  initial release
// ============================================================================
module sha256_round
    import sha256_pkg::*;
(
    input  wire logic [255:0] i_vars,
    input  wire logic [31:0]  i_k,
    input  wire logic [31:0]  i_w,
    output logic      [255:0] o_vars
);
    logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
    logic [31:0] w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_vars;

    assign w_t1 = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
    assign w_t2 = big_sigma0(w_a) + maj(w_a, w_b, w_c);

    assign o_vars = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
endmodule
`default_nettype wire

// File: rtl/sha256_compress.sv
`default_nettype none
// ============================================================================
//  Module   : sha256_compress
//  Purpose  : SHA-256 compression core. Consumes W0..W63 one per accepted
//             cycle, runs 64 rounds and folds the result into the persistent
//             hash state H0..H7, which is exposed directly as the digest.
//  Revision : 1.0  initial release
// ============================================================================
module sha256_compress
    import sha256_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst,
    sha256_compress_if.slave   bus
);
    state_t       r_state;
    logic [5:0]   r_t;
    logic [255:0] r_vars;
    logic [255:0] r_h;
    logic         r_done;

    logic [255:0] w_iv;
    logic [255:0] w_next_vars;
    logic [255:0] w_h_sum;
    logic         w_accept;

    assign w_iv = {c_IV[0], c_IV[1], c_IV[2], c_IV[3],
                   c_IV[4], c_IV[5], c_IV[6], c_IV[7]};

    assign w_accept = (r_state == ROUND) && bus.w_valid_i;

    sha256_round u_round (
        .i_vars (r_vars),
        .i_k    (c_K[r_t]),
        .i_w    (bus.w_i),
        .o_vars (w_next_vars)
    );

    // Per-word feed-forward addition of the working variables into H.
    for (genvar i = 0; i < 8; i++) begin : g_final_add
        assign w_h_sum[255 - 32*i -: 32] = r_h[255 - 32*i -: 32] + r_vars[255 - 32*i -: 32];
    end

    // Block controller: sequences LOAD/ROUND/FINAL and owns t, a..h, H and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_t     <= 6'd0;
            r_vars  <= '0;
            r_h     <= w_iv;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_i) begin
                        r_state <= LOAD;
                        if (bus.init_i) begin
                            r_h <= w_iv;
                        end
                    end
                end
                LOAD: begin
                    r_vars  <= r_h;
                    r_t     <= 6'd0;
                    r_state <= ROUND;
                end
                ROUND: begin
                    if (w_accept) begin
                        r_vars <= w_next_vars;
                        r_t    <= r_t + 6'd1;
                        if (r_t == 6'd63) begin
                            r_state <= FINAL;
                        end
                    end
                end
                FINAL: begin
                    r_h     <= w_h_sum;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.w_ready_o = (r_state == ROUND);
    assign bus.busy_o    = (r_state != IDLE);
    assign bus.round_o   = r_t;
    assign bus.done_o    = r_done;
    assign bus.digest_o  = r_h;
endmodule
`default_nettype wire

// File: tb/tb_sha256_compress.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha256_compress
//  Purpose  : Directed self-checking bench for the SHA-256 compression core.
//             Padded message blocks are expanded locally into W0..W63 and
//             digests are compared against published FIPS 180-4 results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sha256_compress;
    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sched_t [64];

    localparam logic [255:0] c_IV_EXP    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] c_ABC_EXP   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_EMPTY_EXP = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] c_TWO_EXP   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned edge_cnt = 0;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    sha256_compress_if bus ();

    sha256_compress dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Standard message-schedule expansion of one 16-word block.
    function automatic sched_t expand(input blk_t m);
        sched_t w;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) w[i] = m[i];
            else w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                      + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input logic init, output int unsigned start_edge);
        bus.start_i = 1'b1;
        bus.init_i  = init;
        step();
        bus.start_i = 1'b0;
        bus.init_i  = 1'b0;
        start_edge  = edge_cnt;
    endtask

    // Feeds words until 64 (or abort_k) are accepted; optional random stalls
    // and spurious start pulses at t=10 and in FINAL.
    task automatic feed(input sched_t w, input bit stall, input bit inject,
                        input int abort_k, output int stalls);
        int k     = 0;
        int guard = 0;
        int target;
        bit v;
        bit acc;
        target = (abort_k < 0) ? 64 : abort_k;
        stalls = 0;
        while (k < target && guard < 1000) begin
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.w_valid_i = v;
            bus.w_i       = w[k];
            bus.start_i   = inject && (k == 10);
            bus.init_i    = inject && (k == 10);
            acc = v && bus.w_ready_o;
            if (bus.w_ready_o && !v) stalls++;
            step();
            if (acc) k++;
            if (stall) check("round_o_track", 256'(bus.round_o), 256'(k[5:0]));
            guard++;
        end
        bus.w_valid_i = 1'b0;
        bus.start_i   = 1'b0;
        bus.init_i    = 1'b0;
        check("words_accepted", 256'(k), 256'(target));
        if (inject) begin
            bus.start_i = 1'b1;
            bus.init_i  = 1'b1;
            step();
            bus.start_i = 1'b0;
            bus.init_i  = 1'b0;
        end
    endtask

    task automatic wait_done(input int unsigned start_edge, output int unsigned delta);
        int n = 0;
        while (!bus.done_o && n < 200) begin
            step();
            n++;
        end
        check("done_seen", 256'(bus.done_o), 256'(1));
        delta = edge_cnt - start_edge;
    endtask

    initial begin
        blk_t m_abc   = '{0: 32'h61626380, 15: 32'h00000018, default: 32'h0};
        blk_t m_empty = '{0: 32'h80000000, default: 32'h0};
        blk_t m_b1    = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                          32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                          32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                          32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_t m_b2    = '{15: 32'h000001c0, default: 32'h0};
        sched_t      w_abc, w_empty, w_b1, w_b2;
        int unsigned se;
        int unsigned dl;
        int          st;
        int          dn;

        w_abc   = expand(m_abc);
        w_empty = expand(m_empty);
        w_b1    = expand(m_b1);
        w_b2    = expand(m_b2);

        bus.start_i   = 1'b0;
        bus.init_i    = 1'b0;
        bus.w_valid_i = 1'b0;
        bus.w_i       = 32'h0;
        rst           = 1'b1;
        step();
        step();
        check("rst_w_ready", 256'(bus.w_ready_o), 256'(0));
        check("rst_busy",    256'(bus.busy_o),    256'(0));
        check("rst_done",    256'(bus.done_o),    256'(0));
        check("rst_round",   256'(bus.round_o),   256'(0));
        check("rst_digest",  bus.digest_o,        c_IV_EXP);
        rst = 1'b0;
        step();

        // 1: "abc", no stalls
        start_block(1'b1, se);
        check("t1_busy", 256'(bus.busy_o), 256'(1));
        feed(w_abc, 1'b0, 1'b0, -1, st);
        wait_done(se, dl);
        check("t1_digest",  bus.digest_o, c_ABC_EXP);
        check("t1_latency", 256'(dl), 256'(66));

        // 2: empty message; init must reload IV over the "abc" result
        step();
        start_block(1'b1, se);
        check("t2_iv_reload", bus.digest_o, c_IV_EXP);
        feed(w_empty, 1'b0, 1'b0, -1, st);
        wait_done(se, dl);
        check("t2_digest",  bus.digest_o, c_EMPTY_EXP);
        check("t2_latency", 256'(dl), 256'(66));

        // 3: two-block message, block 2 started in the done cycle
        step();
        start_block(1'b1, se);
        feed(w_b1, 1'b0, 1'b0, -1, st);
        wait_done(se, dl);
        start_block(1'b0, se);
        feed(w_b2, 1'b0, 1'b0, -1, st);
        wait_done(se, dl);
        check("t3_digest",  bus.digest_o, c_TWO_EXP);
        check("t3_latency", 256'(dl), 256'(66));

        // 4: "abc" with random stalls
        step();
        start_block(1'b1, se);
        feed(w_abc, 1'b1, 1'b0, -1, st);
        wait_done(se, dl);
        check("t4_digest",  bus.digest_o, c_ABC_EXP);
        check("t4_latency", 256'(dl), 256'(66 + st));

        // 5: reset at t=30, then restart with init=0
        step();
        start_block(1'b1, se);
        feed(w_abc, 1'b0, 1'b0, 30, st);
        check("t5_round_at_abort", 256'(bus.round_o), 256'(30));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_digest_iv", bus.digest_o, c_IV_EXP);
        check("t5_busy",      256'(bus.busy_o), 256'(0));
        check("t5_round",     256'(bus.round_o), 256'(0));
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.done_o) dn++;
            step();
        end
        check("t5_no_done", 256'(dn), 256'(0));
        start_block(1'b0, se);
        feed(w_abc, 1'b0, 1'b0, -1, st);
        wait_done(se, dl);
        check("t5_digest",  bus.digest_o, c_ABC_EXP);
        check("t5_latency", 256'(dl), 256'(66));

        // 6: spurious start (with init) at t=10 and in FINAL
        step();
        start_block(1'b1, se);
        feed(w_abc, 1'b0, 1'b1, -1, st);
        wait_done(se, dl);
        check("t6_digest",  bus.digest_o, c_ABC_EXP);
        check("t6_latency", 256'(dl), 256'(66));
        step();
        check("t6_idle_after", 256'(bus.busy_o), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sha256_compress.md
# sha256_compress

SHA-256 compression core, directly downstream of `msg_sch`. It consumes the 64 scheduled words W0–W63 one per accepted cycle and runs the 64 rounds over working variables a–h. It then adds the result into the running hash state H0–H7, which persists across the blocks of a multi-block message. The core presents the 256-bit digest together with a one-cycle completion pulse.

## Interface
Parameters: none. All constants are fixed by FIPS 180-4.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start_i`  in  1  request to compress one block; accepted only in IDLE
- `init_i`  in  1  sampled with an accepted `start_i`; 1 = first block of a message (H reloaded with the IV)
- `w_valid_i`  in  1  `w_i` carries the next scheduled word Wt
- `w_i`  in  32  scheduled word Wt from `msg_sch`
- `w_ready_o`  out  1  high exactly while in ROUND
- `busy_o`  out  1  high in every state except IDLE
- `round_o`  out  6  index t of the next word to be consumed
- `done_o`  out  1  one-cycle pulse; `digest_o` updated
- `digest_o`  out  256  H0..H7, H0 in [255:224], H7 in [31:0]

## Operation
- States: IDLE → LOAD → ROUND → FINAL → IDLE.
- **IDLE**
  - `start_i` = 1 → LOAD.
  - If `init_i` = 1 at the same time, H := IV (6a09e667 … 5be0cd19).
- **LOAD** (1 cycle)
  - {a..h} := H, using the IV if it was just selected.
  - t := 0.
- **ROUND**
  - Word accepted on each cycle with `w_valid_i` & `w_ready_o`. One round is applied per accepted word:
    - T1 = h + Σ1(e) + Ch(e,f,g) + Kt + Wt
    - T2 = Σ0(a) + Maj(a,b,c)
    - h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2
  - All additions are mod 2^32. Carries are discarded.
  - `w_valid_i` = 0: a..h and t hold (stall).
  - Accepting the word with t = 63 → FINAL.
- **FINAL** (1 cycle)
  - Hi := Hi + {a..h}i, mod 2^32 per word.
  - Next state IDLE, with `done_o` = 1 in that first IDLE cycle.
- **Boundary rules**
  - `start_i` while `busy_o` = 1: ignored, with no effect on H or t.
  - `w_valid_i` outside ROUND: ignored, with no state change.
  - `start_i` in the IDLE cycle in which `done_o` is high: accepted (back-to-back blocks).
  - `init_i` = 0 on the first block after reset: H still holds the IV from reset, so the result is correct.
  - `rst` mid-operation: abort to IDLE, H := IV; no `done_o`.

## Timing
- Reset values:
  - state IDLE
  - `w_ready_o` 0, `busy_o` 0, `done_o` 0, `round_o` 0
  - `digest_o` = IV
- Latency with no stalls:
  - `start_i` sampled at edge N.
  - LOAD during cycle N+1.
  - ROUND during cycles N+2..N+65, consuming W0..W63.
  - FINAL during cycle N+66.
  - `done_o` = 1 and new `digest_o` during cycle N+67.
  - Total 67 cycles. Each stall cycle adds exactly one cycle.
- Output timing:
  - `digest_o` is a direct view of the H registers. It changes only at the FINAL edge, on reset, or on an accepted `start_i` with `init_i` = 1.
  - `round_o` is registered and equals the number of words accepted in the current block.
- Kt selection is combinational from t; there are no pipeline bubbles between rounds.

## Structure
- **Shared package `sha256_pkg`**, also used by `msg_sch`:
  - K[0:63] constant array
  - IV[0:7] constant array
  - functions Ch, Maj, Σ0, Σ1
  - state enum (IDLE, LOAD, ROUND, FINAL)
- **Sub-module `sha256_round`**: purely combinational, taking {a..h}, Kt, Wt → next {a..h}. It is instantiated once.
- **`sha256_compress` itself** holds:
  - FSM
  - round counter t
  - working registers a..h
  - H registers
  - FINAL adders

## Test plan
1. Single block "abc" (W from reference model, `w_valid_i` tied high, `init_i` = 1) → `done_o` at N+67; `digest_o` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
2. Empty message (single padded block) → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
3. Two-block 448-bit "abcdbcdecdefdefg…nopq": block 1 with `init_i` = 1, block 2 started in the `done_o` cycle with `init_i` = 0 → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
4. Stall case: "abc" with `w_valid_i` pseudo-random at 50% → same digest as test 1. `round_o` holds during stalls. `done_o` lands at 67 + stall-count cycles.
5. `rst` asserted at t = 30, then "abc" restarted with `init_i` = 0 → `digest_o` = IV immediately after reset and no `done_o` from the aborted block; the final digest equals test 1.
6. `start_i` pulsed at t = 10 and during FINAL → ignored; digest and cycle count are identical to test 1.
